// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-cycle data memory between the core load/store
// path and an external host port. Every access takes an IDLE -> GNT_* -> IDLE
// pass. The host wins ties. Read data is registered back to the requester.
// Optional feature: define DMEM_ARB_STARVE_EN to add a host-run counter. After
// MAX_HOST_RUN consecutive host wins against a waiting core, the core wins the
// next tie.
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_HOST_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  // core port
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  // host port
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  // memory side
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int unsigned      CNT_W   = 4;
  localparam logic [CNT_W-1:0] RUN_LIM = CNT_W'(MAX_HOST_RUN);

  // 2'b11 is unreachable and decodes as IDLE
  localparam logic [1:0] S_IDLE     = 2'b00;
  localparam logic [1:0] S_GNT_CORE = 2'b01;
  localparam logic [1:0] S_GNT_HOST = 2'b10;

  logic [1:0]        state_q, state_d;
  logic              core_rvalid_q, core_rvalid_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic [CNT_W-1:0]  starve_cnt;
  logic              core_first;

  // Core takes a tie only once the host has used up its allowed run
  assign core_first = (starve_cnt == RUN_LIM);

`ifdef DMEM_ARB_STARVE_EN
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             in_idle;

  assign starve_cnt = starve_cnt_q;
  assign in_idle    = (state_q != S_GNT_CORE) && (state_q != S_GNT_HOST);

  // Count host wins taken while the core is waiting
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == S_GNT_CORE) begin
      starve_cnt_d = '0;
    end else if (in_idle) begin
      if (!core_req) begin
        starve_cnt_d = '0;
      end else if ((state_d == S_GNT_HOST) && (starve_cnt_q != '1)) begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
    end
  end

  // Host-run counter register
  always_ff @(posedge clk) begin
    if (rst) starve_cnt_q <= '0;
    else     starve_cnt_q <= starve_cnt_d;
  end
`else
  assign starve_cnt = '0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state: a grant always returns to IDLE; IDLE arbitrates
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_GNT_CORE, S_GNT_HOST: state_d = S_IDLE;
      default: begin
        if (core_req && (!host_req || core_first)) state_d = S_GNT_CORE;
        else if (host_req)                         state_d = S_GNT_HOST;
      end
    endcase
  end

  // Grant and memory-side outputs; reset kills an in-flight access
  always_comb begin
    core_gnt = 1'b0;
    host_gnt = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (!rst) begin
      case (state_q)
        S_GNT_CORE: begin
          core_gnt = 1'b1;
          mem_we   = core_we;
          mem_addr = core_addr;
          mem_wd   = core_wdata;
        end
        S_GNT_HOST: begin
          host_gnt = 1'b1;
          mem_we   = host_we;
          mem_addr = host_addr;
          mem_wd   = host_wdata;
        end
        default: ;
      endcase
    end
  end

  assign core_stall = core_req & ~core_gnt;

  // Read return: capture memory data at the end of a read grant
  always_comb begin
    core_rvalid_d = core_gnt & ~core_we;
    host_rvalid_d = host_gnt & ~host_we;
    core_rdata_d  = core_rvalid_d ? mem_rd : core_rdata_q;
    host_rdata_d  = host_rvalid_d ? mem_rd : host_rdata_q;
  end

  // Read return registers
  always_ff @(posedge clk) begin
    if (rst) begin
      core_rvalid_q <= 1'b0;
      host_rvalid_q <= 1'b0;
      core_rdata_q  <= '0;
      host_rdata_q  <= '0;
    end else begin
      core_rvalid_q <= core_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
      core_rdata_q  <= core_rdata_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign core_rvalid = core_rvalid_q;
  assign host_rvalid = host_rvalid_q;
  assign core_rdata  = core_rdata_q;
  assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed test-plan scenarios plus randomized traffic, checked
// against a transaction-level model of the arbitration rules and a shadow memory.
module tb_dmem_arbiter;

  localparam int unsigned MAX_RUN = 2;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, core_gnt, core_rvalid, core_stall;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        host_req, host_we, host_gnt, host_rvalid;
  logic [31:0] host_addr, host_wdata, host_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOST_RUN(MAX_RUN)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Memory instance model: combinational read, write at the clock edge
  logic [31:0] mem [64];
  logic        wr_pend;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  assign mem_rd = mem[mem_addr[5:0]];

  // Reference model state
  logic [31:0] shadow [64];
  logic        mg_core, mg_host;    // grant due in the current cycle
  logic        mrv_core, mrv_host;  // rvalid due in the current cycle
  logic [31:0] mrd_core, mrd_host;  // rdata due in the current cycle
  int          run;                 // host wins while the core was waiting
  logic        seen_cg, seen_hg;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Compare all outputs to the model, then advance the model one cycle
  task automatic sample();
    logic        eg_c, eg_h, idle_now, n_c, n_h;
    logic        e_we;
    logic [31:0] e_addr, e_wd;
    @(negedge clk);
    eg_c = mg_core & ~rst;
    eg_h = mg_host & ~rst;
    e_we = 1'b0; e_addr = '0; e_wd = '0;
    if (eg_c) begin
      e_we = core_we; e_addr = core_addr; e_wd = core_wdata;
    end else if (eg_h) begin
      e_we = host_we; e_addr = host_addr; e_wd = host_wdata;
    end
    chk("core_gnt",    64'(core_gnt),    64'(eg_c));
    chk("host_gnt",    64'(host_gnt),    64'(eg_h));
    chk("core_stall",  64'(core_stall),  64'(core_req & ~eg_c));
    chk("core_rvalid", 64'(core_rvalid), 64'(mrv_core));
    chk("host_rvalid", 64'(host_rvalid), 64'(mrv_host));
    chk("core_rdata",  64'(core_rdata),  64'(mrd_core));
    chk("host_rdata",  64'(host_rdata),  64'(mrd_host));
    chk("mem_we",      64'(mem_we),      64'(e_we));
    chk("mem_addr",    64'(mem_addr),    64'(e_addr));
    chk("mem_wd",      64'(mem_wd),      64'(e_wd));
    wr_pend = mem_we; wr_addr = mem_addr[5:0]; wr_data = mem_wd;
    seen_cg = core_gnt; seen_hg = host_gnt;
    // read returns and memory effects of this cycle's access
    mrv_core = eg_c & ~core_we;
    mrv_host = eg_h & ~host_we;
    if (rst) begin
      mrd_core = '0; mrd_host = '0;
    end else begin
      if (mrv_core) mrd_core = shadow[core_addr[5:0]];
      if (mrv_host) mrd_host = shadow[host_addr[5:0]];
    end
    if (eg_c && core_we) shadow[core_addr[5:0]] = core_wdata;
    if (eg_h && host_we) shadow[host_addr[5:0]] = host_wdata;
    // a grant occupies one cycle; only a free cycle may pick the next winner
    idle_now = ~mg_core & ~mg_host;
    n_c = 1'b0; n_h = 1'b0;
    if (!rst && idle_now) begin
      if (core_req && host_req) begin
        if (STARVE && run == int'(MAX_RUN)) n_c = 1'b1;
        else                                 n_h = 1'b1;
      end else if (core_req) n_c = 1'b1;
      else if (host_req)     n_h = 1'b1;
    end
    if (rst || n_c)               run = 0;
    else if (n_h && core_req)     run++;
    else if (idle_now && !core_req) run = 0;
    mg_core = n_c;
    mg_host = n_h;
  endtask

  task automatic adv();
    @(posedge clk);
    if (wr_pend) mem[wr_addr] = wr_data;
    #1;
  endtask

  // Random requesters: hold each access until granted, then maybe issue another
  task automatic drive_random(input int unsigned rate_c, input int unsigned rate_h);
    if (!core_req || seen_cg) begin
      core_req   = ($urandom_range(99) < rate_c);
      core_we    = 1'($urandom_range(1));
      core_addr  = 32'($urandom_range(63));
      core_wdata = $urandom;
    end
    if (!host_req || seen_hg) begin
      host_req   = ($urandom_range(99) < rate_h);
      host_we    = 1'($urandom_range(1));
      host_addr  = 32'($urandom_range(63));
      host_wdata = $urandom;
    end
  endtask

  logic [1:0] gq [16];  // burst grant order: 1 = core, 0 = host, 2 = none
  int         gn;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom | 32'h1;
      if (i == 16) mem[i] = 32'hDEADBEEF;
      if (i == 48) mem[i] = 32'h0000_0055;
      shadow[i] = mem[i];
    end
    mg_core = 0; mg_host = 0; mrv_core = 0; mrv_host = 0;
    mrd_core = '0; mrd_host = '0; run = 0; seen_cg = 0; seen_hg = 0;
    wr_pend = 0; wr_addr = '0; wr_data = '0;
    rst = 1'b1;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    sample(); adv();
    rst = 1'b0;
    sample();
    chk("reset_core_rdata", 64'(core_rdata), 64'h0);
    chk("reset_mem_we",     64'(mem_we),     64'h0);
    adv();

    // Core read of 0x10
    core_req = 1; core_we = 0; core_addr = 32'h10;
    sample(); chk("t1_stall_c0", 64'(core_stall), 64'h1); adv();
    sample(); chk("t1_gnt_c1", 64'(core_gnt), 64'h1); chk("t1_stall_c1", 64'(core_stall), 64'h0); adv();
    core_req = 0;
    sample(); chk("t1_rvalid_c2", 64'(core_rvalid), 64'h1);
    chk("t1_rdata_c2", 64'(core_rdata), 64'hDEADBEEF); adv();
    sample(); adv();

    // Host write 0x20, core reads it back
    host_req = 1; host_we = 1; host_addr = 32'h20; host_wdata = 32'h12345678;
    sample(); adv();
    core_req = 1; core_we = 0; core_addr = 32'h20;
    sample(); chk("t2_hgnt_c1", 64'(host_gnt), 64'h1); adv();
    host_req = 0;
    sample(); chk("t2_cgnt_c2", 64'(core_gnt), 64'h0); adv();
    sample(); chk("t2_cgnt_c3", 64'(core_gnt), 64'h1); adv();
    core_req = 0;
    sample(); chk("t2_rdata_c4", 64'(core_rdata), 64'h12345678); adv();
    sample(); adv();

    // Simultaneous reads: host first, then core
    core_req = 1; core_we = 0; core_addr = 32'h11;
    host_req = 1; host_we = 0; host_addr = 32'h22;
    sample(); adv();
    sample(); chk("t3_hgnt_c1", 64'(host_gnt), 64'h1); chk("t3_addr_c1", 64'(mem_addr), 64'h22); adv();
    host_req = 0;
    sample(); chk("t3_hrdata_c2", 64'(host_rdata), 64'(shadow[34])); adv();
    sample(); chk("t3_cgnt_c3", 64'(core_gnt), 64'h1); chk("t3_addr_c3", 64'(mem_addr), 64'h11); adv();
    core_req = 0;
    sample(); chk("t3_crdata_c4", 64'(core_rdata), 64'(shadow[17])); adv();

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      sample();
      chk("idle_we", 64'(mem_we), 64'h0);
      chk("idle_gnt", 64'({core_gnt, host_gnt, core_rvalid, host_rvalid}), 64'h0);
      adv();
    end

    // Continuous contention: grant order shows the starvation policy
    for (int i = 0; i < 16; i++) gq[i] = 2'd2;
    gn = 0;
    core_req = 1; core_we = 0; core_addr = 32'h5;
    host_req = 1; host_we = 0; host_addr = 32'h6;
    for (int i = 0; i < 30; i++) begin
      sample();
      if ((core_gnt || host_gnt) && gn < 16) begin
        gq[gn] = core_gnt ? 2'd1 : 2'd0;
        gn++;
      end
      adv();
      drive_random(100, 100);
    end
    for (int i = 0; i < 9; i++)
      chk("burst_order", 64'(gq[i]), 64'((STARVE && (i % 3 == 2)) ? 2'd1 : 2'd0));
    for (int i = 0; i < 6; i++) begin
      drive_random(0, 0);
      sample(); adv();
    end
    drive_random(0, 0);

    // Reset during a core write grant
    core_req = 1; core_we = 1; core_addr = 32'h30; core_wdata = 32'hAA;
    sample(); adv();
    rst = 1;
    sample(); chk("t5_mem_we", 64'(mem_we), 64'h0); chk("t5_gnt", 64'(core_gnt), 64'h0); adv();
    rst = 0; core_req = 0;
    sample();
    chk("t5_mem30",  64'(mem[48]),   64'h55);
    chk("t5_crdata", 64'(core_rdata), 64'h0);
    chk("t5_hrdata", 64'(host_rdata), 64'h0);
    chk("t5_rvalid", 64'({core_rvalid, host_rvalid}), 64'h0);
    adv();

    // Randomized traffic at several loads
    for (int seg = 0; seg < 4; seg++) begin
      for (int i = 0; i < 150; i++) begin
        drive_random((seg == 3) ? 100 : 25 + 25 * seg, (seg == 3) ? 60 : 70 - 20 * seg);
        sample(); adv();
      end
    end
    for (int i = 0; i < 8; i++) begin
      drive_random(0, 0);
      sample(); adv();
    end
    for (int i = 0; i < 64; i++) chk("final_mem", 64'(mem[i]), 64'(shadow[i]));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
